// File: rtl/ddr3_cmd_arbiter.sv
// ddr3_cmd_arbiter
// Merges the write-request and read-request ports of the AXI-to-memory
// converter into one registered command stream for the DDR3 command FSM.
// Multi-command sequences stay atomic. Reads are preferred, and a saturating
// counter bounds how long a waiting write can be starved.
// Optional build macro: DDR3_ROW_HIT_PRIO_EN. When it is defined and both
// ports request in IDLE, the port whose {bank,row} matches the last issued
// command is preferred.
module ddr3_cmd_arbiter #(
  parameter int ADDRS        = 32,
  parameter int MEM_ID_WIDTH = 4,
  parameter int BYTE_BITS    = 1,
  parameter int COL_BITS     = 10,
  parameter int BANK_BITS    = 3,
  parameter int ROW_BITS     = 13,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_req_i,
  output logic                    wr_ack_o,
  input  logic                    wr_lst_i,
  input  logic [MEM_ID_WIDTH-1:0] wr_tid_i,
  input  logic [ADDRS-1:0]        wr_adr_i,
  input  logic                    rd_req_i,
  output logic                    rd_ack_o,
  input  logic                    rd_lst_i,
  input  logic [MEM_ID_WIDTH-1:0] rd_tid_i,
  input  logic [ADDRS-1:0]        rd_adr_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic                    cmd_write_o,
  output logic                    cmd_last_o,
  output logic [MEM_ID_WIDTH-1:0] cmd_tid_o,
  output logic [BANK_BITS-1:0]    cmd_bank_o,
  output logic [ROW_BITS-1:0]     cmd_row_o,
  output logic [COL_BITS-1:0]     cmd_col_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WR_SEQ = 2'd1;
  localparam logic [1:0] RD_SEQ = 2'd2;

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam int         BANK_LSB = BYTE_BITS + COL_BITS;
  localparam int         ROW_LSB  = BANK_LSB + BANK_BITS;

  logic [1:0]              state_q, state_d;
  logic [3:0]              starve_q, starve_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic                    cmd_write_q, cmd_write_d;
  logic                    cmd_last_q, cmd_last_d;
  logic [MEM_ID_WIDTH-1:0] cmd_tid_q, cmd_tid_d;
  logic [BANK_BITS-1:0]    cmd_bank_q, cmd_bank_d;
  logic [ROW_BITS-1:0]     cmd_row_q, cmd_row_d;
  logic [COL_BITS-1:0]     cmd_col_q, cmd_col_d;

  logic                    space;
  logic                    gnt_wr, gnt_rd;
  logic                    wr_ack, rd_ack;

  // Address decode: column, then bank, then row above the dropped byte bits.
  logic [COL_BITS-1:0]  wr_col, rd_col;
  logic [BANK_BITS-1:0] wr_bank, rd_bank;
  logic [ROW_BITS-1:0]  wr_row, rd_row;
  logic                 unused_adr;

  assign wr_col  = wr_adr_i[BYTE_BITS +: COL_BITS];
  assign wr_bank = wr_adr_i[BANK_LSB +: BANK_BITS];
  assign wr_row  = wr_adr_i[ROW_LSB +: ROW_BITS];
  assign rd_col  = rd_adr_i[BYTE_BITS +: COL_BITS];
  assign rd_bank = rd_adr_i[BANK_LSB +: BANK_BITS];
  assign rd_row  = rd_adr_i[ROW_LSB +: ROW_BITS];
  // The byte-select bits and the address bits above the row are ignored.
  assign unused_adr = ^{wr_adr_i, rd_adr_i};

`ifdef DDR3_ROW_HIT_PRIO_EN
  // The output register already holds the {bank,row} of the last issued
  // command and is cleared by reset, so it serves as the row-hit reference.
  logic wr_hit, rd_hit;
  assign wr_hit = ({wr_bank, wr_row} == {cmd_bank_q, cmd_row_q});
  assign rd_hit = ({rd_bank, rd_row} == {cmd_bank_q, cmd_row_q});
`endif

  assign space = ~cmd_valid_q | cmd_ready_i;

  // Grant: a locked sequence owns the arbiter. Otherwise reads win unless the
  // waiting write has reached the starvation limit.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    case (state_q)
      WR_SEQ: gnt_wr = wr_req_i;
      RD_SEQ: gnt_rd = rd_req_i;
      default: begin
        if (wr_req_i && rd_req_i) begin
          if (starve_q == LIMIT) begin
            gnt_wr = 1'b1;
`ifdef DDR3_ROW_HIT_PRIO_EN
          end else if (wr_hit && !rd_hit) begin
            gnt_wr = 1'b1;
`endif
          end else begin
            gnt_rd = 1'b1;
          end
        end else begin
          gnt_wr = wr_req_i;
          gnt_rd = rd_req_i;
        end
      end
    endcase
  end

  // The reset_n term keeps the acks low while the block is held in reset.
  assign wr_ack   = gnt_wr & space & reset_n;
  assign rd_ack   = gnt_rd & space & reset_n;
  assign wr_ack_o = wr_ack;
  assign rd_ack_o = rd_ack;

  // Next lock state and starvation count from this cycle's acceptance.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (wr_ack) begin
      state_d  = wr_lst_i ? IDLE : WR_SEQ;
      starve_d = 4'd0;
    end else if (rd_ack) begin
      state_d = rd_lst_i ? IDLE : RD_SEQ;
      if (wr_req_i && (starve_q < LIMIT)) starve_d = starve_q + 4'd1;
    end
  end

  // The output register loads on accept, empties on consume, else holds.
  always_comb begin
    cmd_valid_d = cmd_valid_q & ~cmd_ready_i;
    cmd_write_d = cmd_write_q;
    cmd_last_d  = cmd_last_q;
    cmd_tid_d   = cmd_tid_q;
    cmd_bank_d  = cmd_bank_q;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    if (wr_ack) begin
      cmd_valid_d = 1'b1;
      cmd_write_d = 1'b1;
      cmd_last_d  = wr_lst_i;
      cmd_tid_d   = wr_tid_i;
      cmd_bank_d  = wr_bank;
      cmd_row_d   = wr_row;
      cmd_col_d   = wr_col;
    end else if (rd_ack) begin
      cmd_valid_d = 1'b1;
      cmd_write_d = 1'b0;
      cmd_last_d  = rd_lst_i;
      cmd_tid_d   = rd_tid_i;
      cmd_bank_d  = rd_bank;
      cmd_row_d   = rd_row;
      cmd_col_d   = rd_col;
    end
  end

  // State, counter and output register. Reset discards any pending command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_last_q  <= 1'b0;
      cmd_tid_q   <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_last_q  <= cmd_last_d;
      cmd_tid_q   <= cmd_tid_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_write_o = cmd_write_q;
  assign cmd_last_o  = cmd_last_q;
  assign cmd_tid_o   = cmd_tid_q;
  assign cmd_bank_o  = cmd_bank_q;
  assign cmd_row_o   = cmd_row_q;
  assign cmd_col_o   = cmd_col_q;

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Testbench for ddr3_cmd_arbiter: directed scenarios with literal
// expectations, followed by randomized traffic. A behavioural model compares
// every output on every falling clock edge.
// The row-hit scenario is built only when DDR3_ROW_HIT_PRIO_EN is defined.
module tb_ddr3_cmd_arbiter;
  localparam int ADDRS = 32, MID = 4, BB = 1, CB = 10, BK = 3, RB = 13, LIM = 4;

  logic             clock = 1'b0, reset_n = 1'b0;
  logic             wr_req = 1'b0, wr_lst = 1'b0, rd_req = 1'b0, rd_lst = 1'b0;
  logic [MID-1:0]   wr_tid = '0, rd_tid = '0;
  logic [ADDRS-1:0] wr_adr = '0, rd_adr = '0;
  logic             cmd_ready = 1'b0;
  logic             wr_ack, rd_ack, cmd_valid, cmd_write, cmd_last;
  logic [MID-1:0]   cmd_tid;
  logic [BK-1:0]    cmd_bank;
  logic [RB-1:0]    cmd_row;
  logic [CB-1:0]    cmd_col;

  int checks = 0, errors = 0;
  bit saw_wr = 1'b0, saw_rd = 1'b0;

  always #5 clock = ~clock;

  ddr3_cmd_arbiter #(.ADDRS(ADDRS), .MEM_ID_WIDTH(MID), .BYTE_BITS(BB), .COL_BITS(CB),
                     .BANK_BITS(BK), .ROW_BITS(RB), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_req_i(wr_req), .wr_ack_o(wr_ack), .wr_lst_i(wr_lst), .wr_tid_i(wr_tid), .wr_adr_i(wr_adr),
    .rd_req_i(rd_req), .rd_ack_o(rd_ack), .rd_lst_i(rd_lst), .rd_tid_i(rd_tid), .rd_adr_i(rd_adr),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_write_o(cmd_write),
    .cmd_last_o(cmd_last), .cmd_tid_o(cmd_tid), .cmd_bank_o(cmd_bank),
    .cmd_row_o(cmd_row), .cmd_col_o(cmd_col));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address field arithmetic: shift away the byte bits, then peel off fields.
  function automatic int col_of(input logic [ADDRS-1:0] a);
    return int'((longint'(a) >> BB) % (longint'(1) << CB));
  endfunction
  function automatic int bank_of(input logic [ADDRS-1:0] a);
    return int'((longint'(a) >> (BB + CB)) % (longint'(1) << BK));
  endfunction
  function automatic int row_of(input logic [ADDRS-1:0] a);
    return int'((longint'(a) >> (BB + CB + BK)) % (longint'(1) << RB));
  endfunction
  function automatic logic [ADDRS-1:0] mk(input int bank, input int row, input int col);
    longint v;
    v = (longint'(row) << (BB + CB + BK)) + (longint'(bank) << (BB + CB)) + (longint'(col) << BB);
    return ADDRS'(v);
  endfunction

  // Behavioural model: which port owns the arbiter (0 none, 1 write, 2 read),
  // how many reads have passed a waiting write, and the expected output word.
  int m_lock = 0, m_starve = 0;
  bit m_vld = 0, m_wr = 0, m_last = 0;
  int m_tid = 0, m_bank = 0, m_row = 0, m_col = 0;

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_lock = 0; m_starve = 0; m_vld = 0; m_wr = 0; m_last = 0;
      m_tid = 0; m_bank = 0; m_row = 0; m_col = 0;
    end else begin : cmp
      bit space, gw, gr, wh, rh;
      space = !m_vld || cmd_ready;
      gw = 0; gr = 0; wh = 0; rh = 0;
      if (m_lock == 1) gw = wr_req;
      else if (m_lock == 2) gr = rd_req;
      else if (wr_req && rd_req) begin
        if (m_starve >= LIM) gw = 1;
        else begin
          gr = 1;
`ifdef DDR3_ROW_HIT_PRIO_EN
          wh = (bank_of(wr_adr) == m_bank) && (row_of(wr_adr) == m_row);
          rh = (bank_of(rd_adr) == m_bank) && (row_of(rd_adr) == m_row);
          if (wh && !rh) begin gw = 1; gr = 0; end
`endif
        end
      end else begin
        gw = wr_req; gr = rd_req;
      end
      gw = gw && space;
      gr = gr && space;
      chk("wr_ack", wr_ack, gw);
      chk("rd_ack", rd_ack, gr);
      chk("cmd_valid", cmd_valid, m_vld);
      chk("cmd_write", cmd_write, m_wr);
      chk("cmd_last", cmd_last, m_last);
      chk("cmd_tid", cmd_tid, m_tid);
      chk("cmd_bank", cmd_bank, m_bank);
      chk("cmd_row", cmd_row, m_row);
      chk("cmd_col", cmd_col, m_col);
      if (gw) begin
        m_vld = 1; m_wr = 1; m_last = wr_lst; m_tid = int'(wr_tid);
        m_bank = bank_of(wr_adr); m_row = row_of(wr_adr); m_col = col_of(wr_adr);
        m_lock = wr_lst ? 0 : 1;
        m_starve = 0;
      end else if (gr) begin
        m_vld = 1; m_wr = 0; m_last = rd_lst; m_tid = int'(rd_tid);
        m_bank = bank_of(rd_adr); m_row = row_of(rd_adr); m_col = col_of(rd_adr);
        m_lock = rd_lst ? 0 : 2;
        if (wr_req) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
      end else if (cmd_ready) begin
        m_vld = 0;
      end
    end
  end

  // One clock: note this cycle's acks, then step just past the rising edge.
  task automatic cyc();
    @(negedge clock);
    saw_wr = wr_ack;
    saw_rd = rd_ack;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then an asynchronous reset while a command is pending.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_wr_ack", wr_ack, 0);
    reset_n = 1'b1;
    wr_req = 1; wr_lst = 1; wr_tid = 4'd3; wr_adr = 32'h0012_3456;
    cyc();
    chk("t1_ack", saw_wr, 1);
    wr_req = 0;
    chk("t1_pending", cmd_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", cmd_valid, 0);
    chk("arst_write", cmd_write, 0);
    chk("arst_tid", cmd_tid, 0);
    chk("arst_col", cmd_col, 0);
    chk("arst_bank", cmd_bank, 0);
    chk("arst_row", cmd_row, 0);
    wr_req = 1; wr_tid = 4'd4; wr_adr = mk(1, 2, 3);
    #1 chk("arst_ack_low", wr_ack, 0);
    #7 reset_n = 1'b1;
    cyc();
    chk("post_rst_ack", saw_wr, 1);
    wr_req = 0;

    // Decode and latency of a single read.
    cmd_ready = 1;
    rd_req = 1; rd_lst = 1; rd_tid = 4'd5; rd_adr = 32'h0012_3456;
    cyc();
    chk("t2_ack", saw_rd, 1);
    rd_req = 0;
    chk("t2_valid", cmd_valid, 1);
    chk("t2_write", cmd_write, 0);
    chk("t2_col", cmd_col, 10'h22B);
    chk("t2_bank", cmd_bank, 3'd6);
    chk("t2_row", cmd_row, 13'h048);
    chk("t2_tid", cmd_tid, 5);
    chk("t2_last", cmd_last, 1);

    // A four-beat write sequence holds off a waiting read.
    wr_req = 1; wr_tid = 4'd7;
    for (int i = 0; i < 4; i++) begin
      wr_lst = (i == 3); wr_adr = mk(i, 10 + i, 20 + i);
      cyc();
      chk("t3_wr_ack", saw_wr, 1);
      chk("t3_rd_blocked", saw_rd, 0);
      rd_req = 1; rd_lst = 1; rd_tid = 4'd8; rd_adr = mk(5, 5, 5);
    end
    wr_req = 0;
    cyc();
    chk("t3_rd_after", saw_rd, 1);

    // Starvation: with both ports always requesting, every fifth grant is a write.
    wr_req = 1; wr_lst = 1; rd_req = 1; rd_lst = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4_wr_grant", saw_wr, (i % 5) == 4);
      chk("t4_rd_grant", saw_rd, (i % 5) != 4);
    end
    wr_req = 0; rd_req = 0;
    cyc();

    // Backpressure holds the output word and blocks acceptance.
    cmd_ready = 0;
    wr_req = 1; wr_lst = 1; wr_tid = 4'd9; wr_adr = mk(3, 13'h155, 10'h0AA);
    cyc();
    chk("t5_first_ack", saw_wr, 1);
    wr_tid = 4'd10; wr_adr = mk(4, 13'h0F0, 10'h111);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_no_ack", saw_wr, 0);
      chk("t5_hold_valid", cmd_valid, 1);
      chk("t5_hold_tid", cmd_tid, 9);
      chk("t5_hold_bank", cmd_bank, 3);
      chk("t5_hold_row", cmd_row, 13'h155);
      chk("t5_hold_col", cmd_col, 10'h0AA);
    end
    cmd_ready = 1;
    cyc();
    chk("t5_release_ack", saw_wr, 1);
    chk("t5_next_tid", cmd_tid, 10);
    wr_req = 0;
    cyc();

`ifdef DDR3_ROW_HIT_PRIO_EN
    // Row hit: a write to the open bank/row beats a read elsewhere.
    rd_req = 1; rd_lst = 1; rd_tid = 4'd1; rd_adr = mk(2, 7, 5);
    cyc();
    chk("t6_prime", saw_rd, 1);
    wr_req = 1; wr_lst = 1; wr_tid = 4'd2; wr_adr = mk(2, 7, 9);
    rd_tid = 4'd3; rd_adr = mk(1, 3, 1);
    cyc();
    chk("t6_hit_wr", saw_wr, 1);
    chk("t6_hit_rd", saw_rd, 0);
    wr_req = 0;
    cyc();
    chk("t6_rd_next", saw_rd, 1);
    rd_req = 0;
    cyc();
`endif

    // Randomized traffic; requests stay put until acknowledged.
    saw_wr = 0; saw_rd = 0;
    for (int c = 0; c < 3000; c++) begin
      cmd_ready = ($urandom % 4) != 0;
      if (!wr_req || saw_wr) begin
        wr_req = ($urandom % 4) != 0;
        wr_lst = ($urandom % 3) != 0;
        wr_tid = MID'($urandom);
        wr_adr = ($urandom % 2) ? ADDRS'($urandom)
                                : mk($urandom % 2, $urandom % 2, $urandom % 1024);
      end
      if (!rd_req || saw_rd) begin
        rd_req = ($urandom % 4) != 0;
        rd_lst = ($urandom % 3) != 0;
        rd_tid = MID'($urandom);
        rd_adr = ($urandom % 2) ? ADDRS'($urandom)
                                : mk($urandom % 2, $urandom % 2, $urandom % 1024);
      end
      cyc();
    end
    wr_req = 0; rd_req = 0;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
